// File: rtl/crc_ethernet_pkg.sv
// Shared constants, FSM encoding and the single-bit reflected CRC-32 step
// used by both the serial and unrolled datapaths of crc_ethernet_32bit.
package crc_ethernet_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    // One LSB-first step of the reflected CRC-32 register.
    function automatic logic [31:0] crc32_bit_step(input logic [31:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational 8-step unroll of crc32_bit_step; consumes one byte LSB first.
// Instantiated by crc_ethernet_32bit only when CRC_PARALLEL_EN is defined.
module crc32_byte_update
    import crc_ethernet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] stage [0:8];

    assign stage[0] = crc_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_step
            assign stage[gi+1] = crc32_bit_step(stage[gi], data[gi]);
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/crc_ethernet_32bit.sv
// IEEE 802.3 CRC-32 of one byte per transaction with a registered result and done pulse.
// Define CRC_PARALLEL_EN to replace the 8-cycle bit-serial SHIFT with a one-cycle unrolled update.
module crc_ethernet_32bit
    import crc_ethernet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [CRC_WIDTH-1:0]  CRCOut,
    output logic                  done
);

    crc_state_t             state_reg;
    logic [31:0]            crc_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [2:0]             cnt_reg;
    logic [31:0]            crc_next;

`ifdef CRC_PARALLEL_EN
    crc32_byte_update u_byte_update (
        .crc_in  (crc_reg),
        .data    (data_reg),
        .crc_out (crc_next)
    );
`else
    assign crc_next = crc32_bit_step(crc_reg, data_reg[cnt_reg]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            crc_reg   <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            CRCOut    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        data_reg  <= DataIn;
                        crc_reg   <= CRC32_INIT;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc_reg <= crc_next;
`ifdef CRC_PARALLEL_EN
                    state_reg <= DONE;
`else
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        state_reg <= DONE;
                    end
`endif
                end
                DONE: begin
                    CRCOut    <= crc_reg ^ CRC32_XOROUT;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_ethernet_32bit.sv
// Directed bench for crc_ethernet_32bit: reset, known byte CRCs, latency,
// back-to-back throughput and abort by mid-operation reset.
module tb_crc_ethernet_32bit;

`ifdef CRC_PARALLEL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 9;
`endif
    localparam int SPACING = LAT + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  DataIn;
    logic [31:0] CRCOut;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    crc_ethernet_32bit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .DataIn (DataIn),
        .CRCOut (CRCOut),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // Count done pulses over n cycles while start stays low.
    task automatic count_idle_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
    endtask

    task automatic run_byte(input string tag, input logic [7:0] d, input logic [31:0] exp);
        int n;
        @(negedge clk);
        start  = 1'b1;
        DataIn = d;
        @(posedge clk); #1;          // accepting edge E0
        start  = 1'b0;
        DataIn = ~d;                 // must be ignored, byte already latched
        n = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_done"}, {31'b0, done}, 32'h1);
        check({tag, "_crc"}, CRCOut, exp);
        @(posedge clk); #1;
        check({tag, "_done_fall"}, {31'b0, done}, 32'h0);
        check({tag, "_crc_hold"}, CRCOut, exp);
    endtask

    initial begin
        int pulses;
        int cyc;
        int last_cyc;
        rst    = 1'b1;
        start  = 1'b0;
        DataIn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_crc", CRCOut, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_idle_done(12, pulses);
        check("idle_no_done", pulses, 0);

        run_byte("byte_00", 8'h00, 32'hD202EF8D);
        run_byte("byte_61", 8'h61, 32'hE8B7BE43);
        run_byte("byte_ff", 8'hFF, 32'hFF000000);

        // start held high: ten back-to-back transactions of 0x00
        @(negedge clk);
        start  = 1'b1;
        DataIn = 8'h00;
        pulses   = 0;
        last_cyc = -1;
        cyc      = -1;
        while (pulses < 10 && cyc < 150) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (pulses == 0)
                    check("b2b_first_latency", cyc, LAT);
                else
                    check("b2b_spacing", cyc - last_cyc, SPACING);
                check("b2b_crc", CRCOut, 32'hD202EF8D);
                last_cyc = cyc;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulse_count", pulses, 10);
        count_idle_done(SPACING + 2, pulses);

        // reset four clocks into SHIFT aborts the transaction
        @(negedge clk);
        start  = 1'b1;
        DataIn = 8'h61;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_crc", CRCOut, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_idle_done(12, pulses);
        check("abort_no_done", pulses, 0);
        check("abort_crc_after", CRCOut, 32'h0);

        run_byte("after_abort_61", 8'h61, 32'hE8B7BE43);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
